keypad_scanner: RTL and testbench

//  Scans a 4x4 active-low key matrix and debounces it.

---
 rtl/keypad_scanner.sv | 153 +++++++++++++++
 tb/tb_keypad_scanner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner with sweep-level debounce.
// Produces a one-hot key code, a press strobe and a chord/ghost flag.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] onehot,
  output logic        key_pulse,
  output logic        multi_key
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] acc;
    acc = 5'd0;
    for (int i = 0; i < 16; i++) begin
      acc = acc + {4'd0, v[i]};
    end
    return acc;
  endfunction

  logic [3:0]       row_meta_q, row_sync_q;
  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [11:0]      snap_q, snap_d;
  logic [15:0]      stable_copy_q, stable_copy_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [CNT_W-1:0] new_cnt_s;
  logic [15:0]      onehot_q, onehot_d;
  logic             key_pulse_q, key_pulse_d;
  logic             multi_key_q, multi_key_d;
  logic             slot_end_s, sweep_end_s;
  logic [15:0]      full_s;
  logic [4:0]       pop_s;

  assign row_s       = ~row_sync_q;
  assign slot_end_s  = (div_cnt_q == DIV_LAST);
  assign sweep_end_s = slot_end_s && (col_idx_q == 2'd3);
  assign full_s      = {row_s, snap_q};
  assign pop_s       = popcount16(full_s);

  // Two-flop synchronizer; idle rows read as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Column scan: slot divider, column rotation and per-column row snapshot.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    col_idx_d = col_idx_q;
    col_n_d   = col_n_q;
    snap_d    = snap_q;
    if (slot_end_s) begin
      div_cnt_d = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_n_d   = ~(4'b0001 << col_idx_d);
      if (col_idx_q != 2'd3) begin
        snap_d[{col_idx_q, 2'b00} +: 4] = row_s;
      end else begin
        snap_d = snap_q;
      end
    end else begin
      col_idx_d = col_idx_q;
    end
  end

  // Sweep-level debounce and output decision at each sweep completion.
  always_comb begin
    stable_copy_d = stable_copy_q;
    stable_cnt_d  = stable_cnt_q;
    onehot_d      = onehot_q;
    multi_key_d   = multi_key_q;
    key_pulse_d   = 1'b0;
    if (full_s == stable_copy_q) begin
      new_cnt_s = (stable_cnt_q >= CNT_MAX) ? CNT_MAX : (stable_cnt_q + CNT_W'(1));
    end else begin
      new_cnt_s = CNT_W'(1);
    end
    if (sweep_end_s) begin
      stable_copy_d = full_s;
      stable_cnt_d  = new_cnt_s;
      if (new_cnt_s == CNT_MAX) begin
        case (pop_s)
          5'd0: begin
            onehot_d    = 16'h0000;
            multi_key_d = 1'b0;
          end
          5'd1: begin
            onehot_d    = full_s;
            multi_key_d = 1'b0;
            key_pulse_d = (full_s != onehot_q);
          end
          default: begin
            // Chords and ghost patterns cannot be resolved to one key.
            onehot_d    = 16'h0000;
            multi_key_d = 1'b1;
          end
        endcase
      end else begin
        onehot_d = onehot_q;
      end
    end else begin
      stable_cnt_d = stable_cnt_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      col_idx_q     <= 2'd0;
      col_n_q       <= 4'b1110;
      snap_q        <= 12'h000;
      stable_copy_q <= 16'h0000;
      stable_cnt_q  <= '0;
      onehot_q      <= 16'h0000;
      key_pulse_q   <= 1'b0;
      multi_key_q   <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      col_idx_q     <= col_idx_d;
      col_n_q       <= col_n_d;
      snap_q        <= snap_d;
      stable_copy_q <= stable_copy_d;
      stable_cnt_q  <= stable_cnt_d;
      onehot_q      <= onehot_d;
      key_pulse_q   <= key_pulse_d;
      multi_key_q   <= multi_key_d;
    end
  end

  assign col_n     = col_n_q;
  assign onehot    = onehot_q;
  assign key_pulse = key_pulse_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  localparam int SWEEP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] onehot;
  logic        key_pulse;
  logic        multi_key;
  logic [15:0] press = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int change_cyc = 0;
  logic [16:0] exp_q[$];
  logic [15:0] prev_oh = 16'h0000;
  logic        prev_mk = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .onehot(onehot), .key_pulse(key_pulse), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      logic acc;
      acc = 1'b0;
      for (int c = 0; c < 4; c++) acc = acc | (press[c*4+r] & ~col_n[c]);
      row_n[r] = ~acc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every change of {multi_key, onehot} is matched against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oh = 16'h0000;
      prev_mk = 1'b0;
    end else begin
      if (key_pulse) pulse_cnt++;
      if (onehot !== prev_oh || multi_key !== prev_mk) begin
        change_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_change", {15'd0, multi_key, onehot}, {15'd0, prev_mk, prev_oh});
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check_eq("sb_out", {15'd0, multi_key, onehot}, {15'd0, e});
        end
        prev_oh = onehot;
        prev_mk = multi_key;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input logic mk, input logic [15:0] oh);
    exp_q.push_back({mk, oh});
  endtask

  task automatic settle(input string tag, input int pulses);
    wait_cyc(5 * SWEEP);
    check_eq({tag, "_qempty"}, exp_q.size(), 0);
    check_eq({tag, "_pulses"}, pulse_cnt, pulses);
  endtask

  initial begin
    int press_cyc;
    logic [3:0] col_exp;

    // 1: reset values and column rotation
    #2 rst_n = 1'b0;
    wait_cyc(3);
    check_eq("rst_col_n", col_n, 4'b1110);
    check_eq("rst_onehot", onehot, 16'h0000);
    check_eq("rst_pulse", key_pulse, 1'b0);
    check_eq("rst_multi", multi_key, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      col_exp = ~(4'b0001 << ((i / 4) % 4));
      check_eq("col_step", col_n, col_exp);
    end

    // 2: single press and release
    pulse_cnt = 0;
    expect_out(1'b0, 16'h0200);
    press_cyc = cyc;
    press = 16'h0200;
    settle("press", 1);
    check_eq("press_lat_ok", ((change_cyc - press_cyc) >= 32) && ((change_cyc - press_cyc) <= 68), 1);
    expect_out(1'b0, 16'h0000);
    press = 16'h0000;
    settle("release", 1);

    // 3: bouncing contact, then held
    pulse_cnt = 0;
    expect_out(1'b0, 16'h0200);
    for (int i = 0; i < 5; i++) begin
      press = press ^ 16'h0200;
      wait_cyc(SWEEP);
    end
    check_eq("bounce_hold0", onehot, 16'h0000);
    settle("bounce", 1);
    expect_out(1'b0, 16'h0000);
    press = 16'h0000;
    settle("bounce_rel", 1);

    // 4: chord rejected, then single key accepted
    pulse_cnt = 0;
    expect_out(1'b1, 16'h0000);
    press = 16'h0021;
    settle("chord", 0);
    check_eq("chord_multi", multi_key, 1'b1);
    expect_out(1'b0, 16'h0001);
    press = 16'h0001;
    settle("chord_single", 1);
    expect_out(1'b0, 16'h0000);
    press = 16'h0000;
    settle("chord_rel", 1);

    // 5: roll from one key to another without release
    pulse_cnt = 0;
    expect_out(1'b0, 16'h0008);
    press = 16'h0008;
    settle("roll_a", 1);
    expect_out(1'b0, 16'h1000);
    press = 16'h1000;
    settle("roll_b", 2);
    expect_out(1'b0, 16'h0000);
    press = 16'h0000;
    settle("roll_rel", 2);

    // 6: reset while a key is reported, key still held afterwards
    expect_out(1'b0, 16'h0200);
    press = 16'h0200;
    settle("pre_rst", 3);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_onehot", onehot, 16'h0000);
    check_eq("midrst_col_n", col_n, 4'b1110);
    check_eq("midrst_multi", multi_key, 1'b0);
    wait_cyc(2);
    pulse_cnt = 0;
    expect_out(1'b0, 16'h0200);
    rst_n = 1'b1;
    wait_cyc(47);
    check_eq("rerep_early", onehot, 16'h0000);
    wait_cyc(1);
    check_eq("rerep_exact", onehot, 16'h0200);
    settle("rerep", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
